enc_dec_core: RTL

Hamming SECDED engine directly downstream of the APB register selector. Consumes its CTRL, DATA_IN, CODEWORD_WIDTH and NOISE register outputs plus a start strobe. Performs encode, decode, or full channel (encode, inject noise, decode). Returns the result word, an error count and a one-cycle done pulse for the interrupt/readback logic.

---
 rtl/enc_dec_core.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/enc_dec_core.sv
// Hamming SECDED encode / decode / full-channel engine.
// Optional macro ENC_DEC_ERR_CNT_EN adds a saturating count of
// uncorrectable (double) errors on err_count; otherwise err_count is 0.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for an accepted start
// S_ENC   | build codeword from captured data
// S_NOISE | XOR captured noise mask into the codeword
// S_DEC   | syndrome decode, correct single errors
// S_DONE  | results valid, one-cycle done pulse
module enc_dec_core #(
    parameter int AMBA_WORD = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] NOISE,
    output logic [AMBA_WORD-1:0] data_out,
    output logic                 operation_done,
    output logic [1:0]           num_of_errors,
    output logic                 busy,
    output logic [15:0]          err_count
);

    typedef enum logic [2:0] {S_IDLE, S_ENC, S_NOISE, S_DEC, S_DONE} state_t;

    localparam logic [1:0] OP_ENC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_FULL = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  op_q, wc_q;
    logic [31:0] din_q, noise_q, cw_q;
    logic [31:0] cw_mask, enc_word, dec_src;
    logic [27:0] dec_res;
    logic        accept;

    // Upper register bits carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2], DATA_IN, NOISE};

    // Check bits for the first 26 data columns; the column sequence
    // (non-powers-of-two, ascending) is a common prefix for all widths,
    // so narrower widths just use fewer data bits.
    function automatic logic [4:0] calc_check(input logic [25:0] d);
        logic [4:0] c;
        logic [4:0] idx;
        c   = '0;
        idx = '0;
        for (int v = 3; v < 32; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (d[idx]) c = c ^ 5'(v);
                idx = idx + 5'd1;
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] w, input logic [1:0] wc);
        logic [25:0] d;
        logic [4:0]  c;
        logic [31:0] cw;
        case (wc)
            2'b00:   d = {22'd0, w[3:0]};
            2'b01:   d = {15'd0, w[10:0]};
            default: d = w[25:0];
        endcase
        c = calc_check(d);
        case (wc)
            2'b00: begin
                cw     = {24'd0, 1'b0, c[2:0], d[3:0]};
                cw[7]  = ^cw[6:0];
            end
            2'b01: begin
                cw     = {16'd0, 1'b0, c[3:0], d[10:0]};
                cw[15] = ^cw[14:0];
            end
            default: begin
                cw     = {1'b0, c, d};
                cw[31] = ^cw[30:0];
            end
        endcase
        return cw;
    endfunction

    // Returns {errors[1:0], data[25:0]}; cw must already be masked to n bits.
    function automatic logic [27:0] decode(input logic [31:0] cw, input logic [1:0] wc);
        logic [25:0] d;
        logic [4:0]  rc, s;
        logic [4:0]  idx;
        logic [1:0]  err;
        case (wc)
            2'b00: begin
                d  = {22'd0, cw[3:0]};
                rc = {2'b00, cw[6:4]};
            end
            2'b01: begin
                d  = {15'd0, cw[10:0]};
                rc = {1'b0, cw[14:11]};
            end
            default: begin
                d  = cw[25:0];
                rc = cw[30:26];
            end
        endcase
        s   = calc_check(d) ^ rc;
        err = 2'b00;
        idx = '0;
        if (^cw) begin
            err = 2'b01;
            for (int v = 3; v < 32; v++) begin
                if ((v & (v - 1)) != 0) begin
                    if (5'(v) == s) d[idx] = ~d[idx];
                    idx = idx + 5'd1;
                end
            end
        end else if (s != 5'd0) begin
            err = 2'b10;
        end
        return {err, d};
    endfunction

    assign accept = (state_q == S_IDLE) && start && (CTRL[1:0] != 2'b11);

    // Codeword mask and shared encode/decode datapath.
    always_comb begin
        case (wc_q)
            2'b00:   cw_mask = 32'h0000_00FF;
            2'b01:   cw_mask = 32'h0000_FFFF;
            default: cw_mask = 32'hFFFF_FFFF;
        endcase
        enc_word = encode(din_q, wc_q);
        dec_src  = (op_q == OP_FULL) ? cw_q : (din_q & cw_mask);
        dec_res  = decode(dec_src, wc_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state and status outputs.
    always_comb begin
        state_d        = state_q;
        operation_done = 1'b0;
        busy           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = (CTRL[1:0] == OP_DEC) ? S_DEC : S_ENC;
            end
            S_ENC: begin
                busy    = 1'b1;
                state_d = (op_q == OP_FULL) ? S_NOISE : S_DONE;
            end
            S_NOISE: begin
                busy    = 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                operation_done = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, working codeword and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q          <= OP_ENC;
            wc_q          <= 2'b00;
            din_q         <= '0;
            noise_q       <= '0;
            cw_q          <= '0;
            data_out      <= '0;
            num_of_errors <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= CTRL[1:0];
                        wc_q    <= CODEWORD_WIDTH[1:0];
                        din_q   <= DATA_IN[31:0];
                        noise_q <= NOISE[31:0];
                    end
                end
                S_ENC: begin
                    cw_q <= enc_word;
                    if (op_q != OP_FULL) begin
                        data_out      <= AMBA_WORD'(enc_word);
                        num_of_errors <= 2'b00;
                    end
                end
                S_NOISE: cw_q <= cw_q ^ (noise_q & cw_mask);
                S_DEC: begin
                    data_out      <= AMBA_WORD'(dec_res[25:0]);
                    num_of_errors <= dec_res[27:26];
                end
                default: ;
            endcase
        end
    end

`ifdef ENC_DEC_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of uncorrectable results, bumped on entry to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_cnt_q <= 16'd0;
        else if (state_q == S_DEC && dec_res[27:26] == 2'b10 && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
    end
    assign err_count = err_cnt_q;
`else
    assign err_count = 16'd0;
`endif

endmodule
